// File: rtl/uart2eeprom_wr_control.sv
// uart2eeprom_wr_control: parses {EE C0, addr[23:0], num, num data bytes} from the UART rx
// stream, buffers the payload, issues one page-write request to the IIC byte controller and
// serves the buffered bytes to it on demand.
// Optional feature macro: UART2EE_WR_ACK_EN (send ACK_BYTE to the PC after the write completes).
module uart2eeprom_wr_control #(
    parameter int unsigned  MAX_BYTE_NUM = 64,
    parameter logic [7:0]   ACK_BYTE     = 8'hAA,
    localparam int unsigned NW           = $clog2(MAX_BYTE_NUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_data_valid,
    output logic          wr_byte_req,
    output logic [NW-1:0] wr_byte_num_sub1,
    output logic [23:0]   wr_byte_addr,
    output logic [7:0]    wr_byte_data,
    input  logic          wr_byte_data_req,
    input  logic          wr_byte_busy,
    output logic          cmd_err,
    input  logic          tx_data_ready,
    output logic [7:0]    tx_data,
    output logic          tx_data_req
);

    typedef enum logic [3:0] {
        StIdle, StHdr, StA2, StA1, StA0, StNum, StData, StDiscard, StWrReq, StWrWait
`ifdef UART2EE_WR_ACK_EN
        , StAckReq, StAckWait
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [23:0]     addr_q, addr_d;
    logic [NW-1:0]   num_sub1_q, num_sub1_d;
    logic [NW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            cmd_err_q, cmd_err_d;
    logic            req_q, req_d;
    logic            mem_we;
    logic [7:0]      mem_q [MAX_BYTE_NUM];

    // Third flop holds the previous synced value so edges are seen, not levels: a stale busy
    // from an op still running after reset must not be mistaken for acceptance.
    logic            busy_s1_q, busy_s2_q, busy_s3_q;
    logic            busy_rise, busy_fall;

    assign busy_rise = busy_s2_q & ~busy_s3_q;
    assign busy_fall = ~busy_s2_q & busy_s3_q;

`ifdef UART2EE_WR_ACK_EN
    logic            rdy_s1_q, rdy_s2_q, rdy_s3_q;
    logic            rdy_rise, rdy_fall;
    logic            tx_req_q, tx_req_d;
    logic [7:0]      tx_data_q, tx_data_d;

    assign rdy_rise = rdy_s2_q & ~rdy_s3_q;
    assign rdy_fall = ~rdy_s2_q & rdy_s3_q;
`else
    logic            unused_tx_data_ready;
    assign unused_tx_data_ready = tx_data_ready;
`endif

    // Next-state, parse datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        num_sub1_d = num_sub1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: if (rx_data_valid && rx_data == 8'hEE) state_d = StHdr;
            StHdr: begin
                if (rx_data_valid) begin
                    if (rx_data == 8'hC0)      state_d = StA2;
                    else if (rx_data != 8'hEE) state_d = StIdle;
                end
            end
            StA2: if (rx_data_valid) begin addr_d[23:16] = rx_data; state_d = StA1; end
            StA1: if (rx_data_valid) begin addr_d[15:8]  = rx_data; state_d = StA0; end
            StA0: if (rx_data_valid) begin addr_d[7:0]   = rx_data; state_d = StNum; end
            StNum: begin
                if (rx_data_valid) begin
                    if (rx_data == 8'h00) begin
                        cmd_err_d = 1'b1;
                        state_d   = StIdle;
                    end else if ({1'b0, rx_data} > 9'(MAX_BYTE_NUM)) begin
                        cmd_err_d = 1'b1;
                        cnt_d     = rx_data;
                        state_d   = StDiscard;
                    end else begin
                        num_sub1_d = NW'(rx_data - 8'd1);
                        wr_ptr_d   = '0;
                        state_d    = StData;
                    end
                end
            end
            StData: begin
                if (rx_data_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == num_sub1_q) begin
                        rd_ptr_d = '0;
                        state_d  = StWrReq;
                    end
                end
            end
            // Oversized payload is swallowed so its bytes are never taken as a header
            StDiscard: begin
                if (rx_data_valid) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = StIdle;
                end
            end
            StWrReq: if (busy_rise) state_d = StWrWait;
`ifdef UART2EE_WR_ACK_EN
            StWrWait:  if (busy_fall) state_d = StAckReq;
            StAckReq:  if (rdy_fall)  state_d = StAckWait;
            StAckWait: if (rdy_rise)  state_d = StIdle;
`else
            StWrWait:  if (busy_fall) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

        // Controller pulls bytes; pointer sticks on the last byte for surplus strobes
        if (wr_byte_data_req && (state_q == StWrReq || state_q == StWrWait) &&
            rd_ptr_q != num_sub1_q) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        req_d = (state_d == StWrReq);
`ifdef UART2EE_WR_ACK_EN
        tx_req_d  = (state_d == StAckReq);
        tx_data_d = (state_d == StAckReq) ? ACK_BYTE : tx_data_q;
`endif
    end

    // FSM state, control registers, registered outputs and input synchronisers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            num_sub1_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            cmd_err_q  <= 1'b0;
            req_q      <= 1'b0;
            busy_s1_q  <= 1'b0;
            busy_s2_q  <= 1'b0;
            busy_s3_q  <= 1'b0;
`ifdef UART2EE_WR_ACK_EN
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            rdy_s1_q   <= 1'b0;
            rdy_s2_q   <= 1'b0;
            rdy_s3_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            num_sub1_q <= num_sub1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            cmd_err_q  <= cmd_err_d;
            req_q      <= req_d;
            busy_s1_q  <= wr_byte_busy;
            busy_s2_q  <= busy_s1_q;
            busy_s3_q  <= busy_s2_q;
`ifdef UART2EE_WR_ACK_EN
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
            rdy_s1_q   <= tx_data_ready;
            rdy_s2_q   <= rdy_s1_q;
            rdy_s3_q   <= rdy_s2_q;
`endif
        end
    end

    // Payload buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= rx_data;
    end

    assign wr_byte_req      = req_q;
    assign wr_byte_num_sub1 = num_sub1_q;
    assign wr_byte_addr     = addr_q;
    assign wr_byte_data     = mem_q[rd_ptr_q];
    assign cmd_err          = cmd_err_q;
`ifdef UART2EE_WR_ACK_EN
    assign tx_data_req      = tx_req_q;
    assign tx_data          = tx_data_q;
`else
    assign tx_data_req      = 1'b0;
    assign tx_data          = '0;
`endif

endmodule
